// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the two-requester comparator arbiter: FSM encoding,
// requester index constants and a grant-to-index helper.
package cmp_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  // Grants are one-hot, so requester 1 owns the slot exactly when bit 1 is set.
  function automatic logic grant_to_id(input logic [1:0] grant);
    return grant[1] ? REQ_ID_1 : REQ_ID_0;
  endfunction

endpackage

// File: rtl/eq_cmp.sv
// Equality comparator for two (SIZE+1)-bit operands.
module eq_cmp #(
  parameter int SIZE = 31
) (
  input  logic [SIZE:0] a,
  input  logic [SIZE:0] b,
  output logic          equal
);

  assign equal = (a == b);

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone valid always wins, a tie goes to the
// requester named by the priority pointer. Output grant is one-hot or zero.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Shares one equality comparator between two requesters, one transaction at a time.
// Define CMP_ARBITER_BYPASS_EN to skip the CMP state and compare on the accept edge.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int SIZE = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [SIZE:0] req0_a,
  input  logic [SIZE:0] req0_b,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [SIZE:0] req1_a,
  input  logic [SIZE:0] req1_b,
  output logic          req1_ready,
  output logic          resp_valid,
  output logic          resp_id,
  output logic          resp_equal,
  input  logic          resp_ready
);

  state_t        state;
  logic          ptr;
  logic [1:0]    grant;
  logic          idle_open;
  logic          accept;
  logic          acc_id;
  logic [SIZE:0] sel_a;
  logic [SIZE:0] sel_b;
  logic [SIZE:0] cmp_a;
  logic [SIZE:0] cmp_b;
  logic          equal;

  rr_arbiter2 u_rr (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr),
    .grant (grant)
  );

  // Readys are suppressed while reset is asserted so nothing is offered mid-reset.
  assign idle_open  = (state == IDLE) && !rst;
  assign req0_ready = idle_open & grant[0];
  assign req1_ready = idle_open & grant[1];
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign acc_id     = grant_to_id(grant);
  assign sel_a      = (acc_id == REQ_ID_1) ? req1_a : req0_a;
  assign sel_b      = (acc_id == REQ_ID_1) ? req1_b : req0_b;

`ifdef CMP_ARBITER_BYPASS_EN
  assign cmp_a = sel_a;
  assign cmp_b = sel_b;
`else
  logic [SIZE:0] a_q;
  logic [SIZE:0] b_q;
  logic          id_q;

  assign cmp_a = a_q;
  assign cmp_b = b_q;
`endif

  eq_cmp #(.SIZE(SIZE)) u_eq (
    .a     (cmp_a),
    .b     (cmp_b),
    .equal (equal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_equal <= 1'b0;
`ifndef CMP_ARBITER_BYPASS_EN
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            ptr <= ~acc_id;
`ifdef CMP_ARBITER_BYPASS_EN
            resp_equal <= equal;
            resp_id    <= acc_id;
            resp_valid <= 1'b1;
            state      <= RESP;
`else
            a_q   <= sel_a;
            b_q   <= sel_b;
            id_q  <= acc_id;
            state <= CMP;
`endif
          end
        end
`ifndef CMP_ARBITER_BYPASS_EN
        CMP: begin
          resp_equal <= equal;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
`endif
        // Result fields are left untouched here so they stay stable under stall.
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: a vector table for basic traffic plus
// hand-written sequences for stall, reset abort and sustained round-robin.
module tb_cmp_arbiter;

  localparam int SIZE = 31;
`ifdef CMP_ARBITER_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk;
  logic          rst;
  logic          req0_valid;
  logic [SIZE:0] req0_a;
  logic [SIZE:0] req0_b;
  logic          req0_ready;
  logic          req1_valid;
  logic [SIZE:0] req1_a;
  logic [SIZE:0] req1_b;
  logic          req1_ready;
  logic          resp_valid;
  logic          resp_id;
  logic          resp_equal;
  logic          resp_ready;

  int checks = 0;
  int errors = 0;

  cmp_arbiter #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_equal (resp_equal),
    .resp_ready (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {req0_ready, req1_ready, resp_valid, resp_id, resp_equal}.
  typedef struct {
    string         name;
    logic          r;
    logic          v0;
    logic [SIZE:0] a0;
    logic [SIZE:0] b0;
    logic          v1;
    logic [SIZE:0] a1;
    logic [SIZE:0] b1;
    logic          rr;
    logic [4:0]    exp;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input string name, input logic r,
                              input logic v0, input logic [SIZE:0] a0, input logic [SIZE:0] b0,
                              input logic v1, input logic [SIZE:0] a1, input logic [SIZE:0] b1,
                              input logic rr, input logic [4:0] exp);
    vec_t v;
    v.name = name; v.r = r; v.v0 = v0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.rr = rr; v.exp = exp;
    return v;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic applyStimulus(input logic r, input logic v0, input logic [SIZE:0] a0,
                               input logic [SIZE:0] b0, input logic v1, input logic [SIZE:0] a1,
                               input logic [SIZE:0] b1, input logic rr);
    @(posedge clk);
    #1;
    rst        = r;
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    resp_ready = rr;
    #1;
  endtask

  // resp_id/resp_equal are only meaningful while resp_valid is expected high,
  // unless all_bits forces a full compare (used for the post-reset state).
  task automatic checkOutput(input string name, input logic [4:0] exp, input logic all_bits);
    logic [4:0] got;
    logic [4:0] mask;
    got  = {req0_ready, req1_ready, resp_valid, resp_id, resp_equal};
    mask = (exp[2] || all_bits) ? 5'b11111 : 5'b11100;
    checks++;
    if ((got & mask) !== (exp & mask)) begin
      errors++;
      $display("[TB] FAIL %s got=%b want=%b (r0rdy r1rdy rvalid rid req)", name, got, exp);
    end
  endtask

  task automatic idleStep(input logic rr);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, rr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic       exp_ptr;
    logic [SIZE:0] x;

    rst = 1'b1; req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; resp_ready = 1'b0;

    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("reset_hold", 5'b00000, 1'b1);
    idleStep(1'b0);
    checkOutput("reset_state", 5'b00000, 1'b1);

    tbl[0]  = mk("t_single_accept", 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 1, 5'b10000);
    tbl[1]  = mk("t_single_cmp",    0, 0, 0, 0, 0, 0, 0, 1, 5'b00000);
    tbl[2]  = mk("t_single_resp",   0, 0, 0, 0, 0, 0, 0, 1, 5'b00101);
    tbl[3]  = mk("t_rst_between",   1, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[4]  = mk("t_both_grant0",   0, 1, 32'h3, 32'h4, 1, 32'h1, 32'h2, 0, 5'b10000);
    tbl[5]  = mk("t_both_cmp0",     0, 0, 0, 0, 1, 32'h1, 32'h2, 0, 5'b00000);
    tbl[6]  = mk("t_both_resp0",    0, 0, 0, 0, 1, 32'h1, 32'h2, 1, 5'b00100);
    tbl[7]  = mk("t_both_grant1",   0, 0, 0, 0, 1, 32'h1, 32'h2, 0, 5'b01000);
    tbl[8]  = mk("t_both_cmp1",     0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    tbl[9]  = mk("t_both_resp1",    0, 0, 0, 0, 0, 0, 0, 1, 5'b00110);
    tbl[10] = mk("t_back_idle",     0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].r, tbl[i].v0, tbl[i].a0, tbl[i].b0,
                    tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
      checkOutput(tbl[i].name, tbl[i].exp, 1'b0);
    end

    // Stall: result must hold and both readys stay low while the consumer waits.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'hA5, 32'h5A, 1'b0);
    checkOutput("stall_grant", 5'b01000, 1'b0);
    for (int i = 0; i < LAT - 1; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h7, 32'h7, 1'b1, 32'h9, 32'h9, 1'b0);
      checkOutput("stall_cmp", 5'b00000, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h7, 32'h7, 1'b1, 32'h9, 32'h9, 1'b0);
      checkOutput("stall_hold", 5'b00110, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 32'h7, 32'h7, 1'b1, 32'h9, 32'h9, 1'b1);
    checkOutput("stall_release", 5'b00110, 1'b0);
    idleStep(1'b0);
    checkOutput("stall_idle", 5'b00000, 1'b0);

    // Reset right after accept aborts the transaction and clears the pointer.
    applyStimulus(1'b0, 1'b1, 32'h1, 32'h1, 1'b0, '0, '0, 1'b0);
    checkOutput("abort_grant", 5'b10000, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("abort_rst", {2'b00, (LAT == 1), 1'b0, 1'b1}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idleStep(1'b1);
      checkOutput("abort_no_resp", 5'b00000, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 32'h2, 32'h2, 1'b1, 32'h3, 32'h3, 1'b0);
    checkOutput("abort_ptr_zero", 5'b10000, 1'b0);
    for (int i = 0; i < LAT - 1; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'h3, 32'h3, 1'b0);
      checkOutput("abort_cmp", 5'b00000, 1'b0);
    end
    idleStep(1'b1);
    checkOutput("abort_resp", 5'b00101, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idleStep(1'b0);
      checkOutput("dropped_no_txn", 5'b00000, 1'b0);
    end

    // Sustained contention: grants alternate; operands differ only in the MSB.
    exp_ptr = 1'b1;
    for (int t = 0; t < 8; t++) begin
      x = (32'h100 * t) + t;
      applyStimulus(1'b0, 1'b1, x | 32'h8000_0000, x, 1'b1, x, x ^ 32'h8000_0000, 1'b0);
      checkOutput("rr_grant", exp_ptr ? 5'b01000 : 5'b10000, 1'b0);
      for (int i = 0; i < LAT - 1; i++) begin
        applyStimulus(1'b0, 1'b1, x | 32'h8000_0000, x, 1'b1, x, x ^ 32'h8000_0000, 1'b0);
        checkOutput("rr_cmp", 5'b00000, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, x | 32'h8000_0000, x, 1'b1, x, x ^ 32'h8000_0000, 1'b1);
      checkOutput("rr_resp", {3'b001, exp_ptr, 1'b0}, 1'b0);
      exp_ptr = ~exp_ptr;
    end
    idleStep(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
